// File: rtl/engine_axi_master.sv
// engine_axi_master: turns engine-side burst requests into AXI4 read and write
// bursts. The read and write paths are two independent FSMs; beat data is a
// zero-latency pass-through while the matching FSM is in its data phase.
//
// state   | meaning
// R_IDLE  | read request port open, no burst in flight
// R_AR    | AR address presented, waiting for arready
// R_DATA  | forwarding R beats to the engine until rlast
// W_IDLE  | write request port open, no burst in flight
// W_AW    | AW address presented, waiting for awready
// W_DATA  | forwarding engine beats onto W until wlast
// W_RESP  | waiting for the B response
module engine_axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [4:0]              rd_req_len,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    output logic [DATA_WIDTH-1:0]   rd_rdata,
    output logic                    rd_valid,
    output logic                    rd_last,
    input  logic                    rd_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
    input  logic [4:0]              wr_req_len,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    input  logic                    wr_last,
    output logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    axi_err
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    r_state_t              r_state_q;
    w_state_t              w_state_q;
    logic [ADDR_WIDTH-1:0] araddr_q, awaddr_q;
    logic [7:0]            arlen_q, awlen_q;
    logic [7:0]            r_cnt_q;
    logic                  rd_req_ready_q, arvalid_q, r_data_q;
    logic                  wr_req_ready_q, awvalid_q, w_data_q, bready_q;
    logic                  axi_err_q;
    logic                  r_hs, w_last_hs, b_hs;
    logic                  rd_err_set, wr_err_set;

    assign r_hs      = rvalid & rready;
    assign w_last_hs = wvalid & wready & wlast;
    assign b_hs      = bvalid & bready;

    // Read burst sequencing: latch request, present AR, count R beats to rlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= R_IDLE;
            araddr_q       <= '0;
            arlen_q        <= '0;
            r_cnt_q        <= '0;
            rd_req_ready_q <= 1'b1;
            arvalid_q      <= 1'b0;
            r_data_q       <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (rd_req_valid) begin
                        araddr_q       <= rd_req_addr;
                        arlen_q        <= {3'b000, rd_req_len};
                        r_cnt_q        <= '0;
                        rd_req_ready_q <= 1'b0;
                        arvalid_q      <= 1'b1;
                        r_state_q      <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        r_data_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_cnt_q <= r_cnt_q + 8'd1;
                        // Only rlast ends the burst, even if the count disagrees.
                        if (rlast) begin
                            r_data_q       <= 1'b0;
                            rd_req_ready_q <= 1'b1;
                            r_state_q      <= R_IDLE;
                        end
                    end
                end
                default: begin
                    rd_req_ready_q <= 1'b1;
                    arvalid_q      <= 1'b0;
                    r_data_q       <= 1'b0;
                    r_state_q      <= R_IDLE;
                end
            endcase
        end
    end

    // Write burst sequencing: latch request, present AW, pass W beats, take B.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q      <= W_IDLE;
            awaddr_q       <= '0;
            awlen_q        <= '0;
            wr_req_ready_q <= 1'b1;
            awvalid_q      <= 1'b0;
            w_data_q       <= 1'b0;
            bready_q       <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (wr_req_valid) begin
                        awaddr_q       <= wr_req_addr;
                        awlen_q        <= {3'b000, wr_req_len};
                        wr_req_ready_q <= 1'b0;
                        awvalid_q      <= 1'b1;
                        w_state_q      <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        w_data_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_last_hs) begin
                        w_data_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready_q       <= 1'b0;
                        wr_req_ready_q <= 1'b1;
                        w_state_q      <= W_IDLE;
                    end
                end
                default: begin
                    wr_req_ready_q <= 1'b1;
                    awvalid_q      <= 1'b0;
                    w_data_q       <= 1'b0;
                    bready_q       <= 1'b0;
                    w_state_q      <= W_IDLE;
                end
            endcase
        end
    end

    // Bad responses, early rlast and missing rlast all flag the same error.
    assign rd_err_set = r_hs & ((rresp != 2'b00) ||
                                (rlast && (r_cnt_q != arlen_q)) ||
                                (!rlast && (r_cnt_q == arlen_q)));
    assign wr_err_set = b_hs & (bresp != 2'b00);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_err_q <= 1'b0;
        end else if (rd_err_set || wr_err_set) begin
            axi_err_q <= 1'b1;
        end
    end

    assign rd_req_ready = rd_req_ready_q;
    assign araddr       = araddr_q;
    assign arlen        = arlen_q;
    assign arsize       = 3'b010;
    assign arburst      = 2'b01;
    assign arvalid      = arvalid_q;
    assign rready       = r_data_q & rd_ready;
    assign rd_valid     = r_data_q & rvalid;
    assign rd_last      = r_data_q & rlast;
    assign rd_rdata     = rdata;

    assign wr_req_ready = wr_req_ready_q;
    assign awaddr       = awaddr_q;
    assign awlen        = awlen_q;
    assign awsize       = 3'b010;
    assign awburst      = 2'b01;
    assign awvalid      = awvalid_q;
    assign wvalid       = w_data_q & wr_valid;
    assign wlast        = w_data_q & wr_last;
    assign wr_ready     = w_data_q & wready;
    assign wdata        = wr_data;
    assign wstrb        = '1;
    assign bready       = bready_q;

    assign axi_err      = axi_err_q;

endmodule

// File: tb/tb_engine_axi_master.sv
// Testbench for engine_axi_master: directed bursts with an AXI slave model,
// expected AR/AW/R/W traffic queued at issue time and checked by a monitor.
module tb_engine_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_req_addr = '0;
    logic [4:0]  rd_req_len = '0;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [31:0] rd_rdata;
    logic        rd_valid, rd_last;
    logic        rd_ready = 1'b1;
    logic [31:0] wr_req_addr = '0;
    logic [4:0]  wr_req_len = '0;
    logic        wr_req_valid = 1'b0;
    logic        wr_req_ready;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, awvalid;
    logic        arready = 1'b0;
    logic        awready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        axi_err;

    always #5 clk = ~clk;

    engine_axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_ready(rd_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid),
        .wr_req_ready(wr_req_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_last(wr_last), .wr_ready(wr_ready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .axi_err(axi_err)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] len;} ax_t;
    typedef struct packed {logic [31:0] data; logic last;} beat_t;

    ax_t   exp_ar[$];
    ax_t   exp_aw[$];
    beat_t exp_r[$];
    beat_t exp_w[$];
    int    checks = 0;
    int    fails = 0;
    bit    r_stall = 1'b0;
    bit    w_stall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: got activity/timeout expected none", nm);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample at negedge, return just after the posedge that completes the event.
    task automatic wait_hs(input int which, input string nm);
        bit hs;
        int n;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            case (which)
                0: hs = arvalid && arready;
                1: hs = rvalid && rready;
                2: hs = awvalid && awready;
                3: hs = wr_valid && wr_ready;
                4: hs = bvalid && bready;
                5: hs = rd_req_valid && rd_req_ready;
                6: hs = wr_req_valid && wr_req_ready;
                7: hs = arvalid;
                default: hs = awvalid;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) miss({nm, "_timeout"});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ":arvalid"}, 32'(arvalid), 32'd0);
        chk({nm, ":awvalid"}, 32'(awvalid), 32'd0);
        chk({nm, ":wvalid"}, 32'(wvalid), 32'd0);
        chk({nm, ":rready"}, 32'(rready), 32'd0);
        chk({nm, ":bready"}, 32'(bready), 32'd0);
        chk({nm, ":rd_valid"}, 32'(rd_valid), 32'd0);
        chk({nm, ":wr_ready"}, 32'(wr_ready), 32'd0);
        chk({nm, ":rd_req_ready"}, 32'(rd_req_ready), 32'd1);
        chk({nm, ":wr_req_ready"}, 32'(wr_req_ready), 32'd1);
        chk({nm, ":axi_err"}, 32'(axi_err), 32'd0);
        chk({nm, ":araddr"}, araddr, 32'd0);
        chk({nm, ":awaddr"}, awaddr, 32'd0);
        chk({nm, ":arlen"}, 32'(arlen), 32'd0);
        chk({nm, ":awlen"}, 32'(awlen), 32'd0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        chk_idle({nm, "_during"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle({nm, "_after"});
        @(posedge clk);
        #1;
    endtask

    task automatic rd_slave(input logic [31:0] d0, input int nbeats, input int last_at,
                            input int ar_dly, input logic [1:0] resp);
        wait_hs(7, "arvalid");
        cyc(ar_dly);
        arready = 1'b1;
        wait_hs(0, "ar_hs");
        arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (r_stall) cyc($urandom_range(0, 2));
            rvalid = 1'b1;
            rdata  = d0 + 32'(i);
            rlast  = (i == last_at);
            rresp  = resp;
            wait_hs(1, "r_hs");
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
    endtask

    task automatic rd_op(input logic [31:0] addr, input logic [4:0] len, input logic [31:0] d0,
                         input int nbeats, input int last_at, input int ar_dly,
                         input logic [1:0] resp);
        ax_t   a;
        beat_t b;
        a.addr = addr;
        a.len  = {3'b000, len};
        exp_ar.push_back(a);
        for (int i = 0; i < nbeats; i++) begin
            b.data = d0 + 32'(i);
            b.last = (i == last_at);
            exp_r.push_back(b);
        end
        rd_req_addr  = addr;
        rd_req_len   = len;
        rd_req_valid = 1'b1;
        wait_hs(5, "rd_req_hs");
        rd_req_valid = 1'b0;
        rd_slave(d0, nbeats, last_at, ar_dly, resp);
    endtask

    task automatic wr_drv(input logic [31:0] d0, input int nbeats, input int total);
        for (int i = 0; i < nbeats; i++) begin
            if (w_stall) cyc($urandom_range(0, 1));
            wr_valid = 1'b1;
            wr_data  = d0 + 32'(i);
            wr_last  = (i == total - 1);
            wait_hs(3, "wr_beat_hs");
            wr_valid = 1'b0;
            wr_last  = 1'b0;
        end
    endtask

    task automatic wr_slave(input int aw_dly, input int b_dly, input logic [1:0] resp);
        bit hs;
        int n;
        wait_hs(8, "awvalid");
        for (int k = 0; k < aw_dly; k++) begin
            @(negedge clk);
            chk("wr_ready_before_aw", 32'(wr_ready), 32'd0);
            chk("wvalid_before_aw", 32'(wvalid), 32'd0);
            @(posedge clk);
            #1;
        end
        awready = 1'b1;
        wait_hs(2, "aw_hs");
        awready = 1'b0;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            chk("bready_in_wdata", 32'(bready), 32'd0);
            hs = wvalid && wready && wlast;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) miss("wlast_timeout");
        for (int k = 0; k < b_dly; k++) begin
            @(negedge clk);
            chk("bready_in_wresp", 32'(bready), 32'd1);
            chk("wr_req_ready_in_wresp", 32'(wr_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bvalid = 1'b1;
        bresp  = resp;
        wait_hs(4, "b_hs");
        bvalid = 1'b0;
        bresp  = 2'b00;
        @(negedge clk);
        chk("wr_req_ready_after_b", 32'(wr_req_ready), 32'd1);
        chk("bready_after_b", 32'(bready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [4:0] len, input logic [31:0] d0,
                         input int aw_dly, input int b_dly, input logic [1:0] resp);
        ax_t   a;
        beat_t b;
        int    n;
        n = int'(len) + 1;
        a.addr = addr;
        a.len  = {3'b000, len};
        exp_aw.push_back(a);
        for (int i = 0; i < n; i++) begin
            b.data = d0 + 32'(i);
            b.last = (i == n - 1);
            exp_w.push_back(b);
        end
        wr_req_addr  = addr;
        wr_req_len   = len;
        wr_req_valid = 1'b1;
        wait_hs(6, "wr_req_hs");
        wr_req_valid = 1'b0;
        fork
            wr_drv(d0, n, n);
            wr_slave(aw_dly, b_dly, resp);
        join
    endtask

    // Engine/slave ready stalls, randomised only while stalls are enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_ready = r_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            wready   = w_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: compare every presented AR/AW and every R/W handshake to the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arvalid) begin
                    if (exp_ar.size() == 0) miss("ar_unexpected");
                    else begin
                        chk("araddr", araddr, exp_ar[0].addr);
                        chk("arlen", 32'(arlen), 32'(exp_ar[0].len));
                        chk("arsize", 32'(arsize), 32'd2);
                        chk("arburst", 32'(arburst), 32'd1);
                        if (arready) void'(exp_ar.pop_front());
                    end
                end
                if (awvalid) begin
                    if (exp_aw.size() == 0) miss("aw_unexpected");
                    else begin
                        chk("awaddr", awaddr, exp_aw[0].addr);
                        chk("awlen", 32'(awlen), 32'(exp_aw[0].len));
                        chk("awsize", 32'(awsize), 32'd2);
                        chk("awburst", 32'(awburst), 32'd1);
                        if (awready) void'(exp_aw.pop_front());
                    end
                end
                if (rd_valid) chk("rready_follows_rd_ready", 32'(rready), 32'(rd_ready));
                if (rd_valid && rd_ready) begin
                    if (exp_r.size() == 0) miss("r_unexpected");
                    else begin
                        chk("rd_rdata", rd_rdata, exp_r[0].data);
                        chk("rd_last", 32'(rd_last), 32'(exp_r[0].last));
                        if (rd_last) chk("rd_req_ready_at_rlast", 32'(rd_req_ready), 32'd0);
                        void'(exp_r.pop_front());
                    end
                end
                if (wvalid) chk("wr_ready_follows_wready", 32'(wr_ready), 32'(wready));
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) miss("w_unexpected");
                    else begin
                        chk("wdata", wdata, exp_w[0].data);
                        chk("wlast", 32'(wlast), 32'(exp_w[0].last));
                        chk("wstrb", 32'(wstrb), 32'hf);
                        if (wlast) chk("wr_req_ready_at_wlast", 32'(wr_req_ready), 32'd0);
                        void'(exp_w.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("reset");

        // Single read, arready 3 cycles late.
        rd_op(32'h0000_1000, 5'd7, 32'hA000_0000, 8, 7, 3, 2'b00);
        @(negedge clk);
        chk("rd_single_err", 32'(axi_err), 32'd0);
        chk("rd_single_idle", 32'(rd_req_ready), 32'd1);
        @(posedge clk); #1;

        // Single write, wready toggling, B two cycles after wlast.
        w_stall = 1'b1;
        wr_op(32'h0000_2000, 5'd3, 32'hB000_0000, 2, 2, 2'b00);
        w_stall = 1'b0;
        @(negedge clk);
        chk("wr_single_err", 32'(axi_err), 32'd0);
        @(posedge clk); #1;

        // Concurrent read and write with stalls on both sides.
        r_stall = 1'b1;
        w_stall = 1'b1;
        fork
            rd_op(32'h0000_7000, 5'd7, 32'h1111_0000, 8, 7, 1, 2'b00);
            wr_op(32'h0000_8000, 5'd7, 32'h2222_0000, 2, 1, 2'b00);
        join
        r_stall = 1'b0;
        w_stall = 1'b0;
        @(negedge clk);
        chk("concurrent_err", 32'(axi_err), 32'd0);
        @(posedge clk); #1;

        // Single-beat bursts.
        rd_op(32'h0000_9000, 5'd0, 32'h3333_0000, 1, 0, 0, 2'b00);
        wr_op(32'h0000_A000, 5'd0, 32'h4444_0000, 0, 0, 2'b00);
        @(negedge clk);
        chk("len0_err", 32'(axi_err), 32'd0);
        @(posedge clk); #1;

        // Early rlast on beat 3 of a len-7 read; flag stays set.
        rd_op(32'h0000_3000, 5'd7, 32'h5555_0000, 3, 2, 0, 2'b00);
        @(negedge clk);
        chk("early_rlast_err", 32'(axi_err), 32'd1);
        @(posedge clk); #1;
        rd_op(32'h0000_3100, 5'd0, 32'h5656_0000, 1, 0, 0, 2'b00);
        cyc(3);
        @(negedge clk);
        chk("err_sticky", 32'(axi_err), 32'd1);
        @(posedge clk); #1;
        do_reset("clear_err1");

        // rlast missing at the final expected beat.
        rd_op(32'h0000_3200, 5'd0, 32'h5757_0000, 2, 1, 0, 2'b00);
        @(negedge clk);
        chk("missing_rlast_err", 32'(axi_err), 32'd1);
        @(posedge clk); #1;
        do_reset("clear_err2");

        // SLVERR on B.
        wr_op(32'h0000_3300, 5'd0, 32'h5858_0000, 0, 0, 2'b10);
        @(negedge clk);
        chk("bresp_err", 32'(axi_err), 32'd1);
        @(posedge clk); #1;
        do_reset("clear_err3");

        // SLVERR on R.
        rd_op(32'h0000_3400, 5'd0, 32'h5959_0000, 1, 0, 0, 2'b10);
        @(negedge clk);
        chk("rresp_err", 32'(axi_err), 32'd1);
        @(posedge clk); #1;
        do_reset("clear_err4");

        // Reset in the middle of both data phases.
        begin
            ax_t   a;
            beat_t b;
            a.addr = 32'h0000_5000; a.len = 8'd7; exp_ar.push_back(a);
            a.addr = 32'h0000_6000; a.len = 8'd7; exp_aw.push_back(a);
            for (int i = 0; i < 8; i++) begin
                b.data = 32'hC000_0000 + 32'(i); b.last = (i == 7); exp_r.push_back(b);
                b.data = 32'hD000_0000 + 32'(i); b.last = (i == 7); exp_w.push_back(b);
            end
        end
        rd_req_addr = 32'h0000_5000; rd_req_len = 5'd7; rd_req_valid = 1'b1;
        wr_req_addr = 32'h0000_6000; wr_req_len = 5'd7; wr_req_valid = 1'b1;
        wait_hs(5, "rd_req_mid");
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        fork
            rd_slave(32'hC000_0000, 4, -1, 0, 2'b00);
            wr_drv(32'hD000_0000, 2, 8);
            begin
                wait_hs(8, "awvalid_mid");
                awready = 1'b1;
                wait_hs(2, "aw_mid");
                awready = 1'b0;
            end
        join
        rvalid = 1'b1; rdata = 32'hC000_0004;
        wr_valid = 1'b1; wr_data = 32'hD000_0002;
        rst = 1'b1;
        cyc(1);
        @(negedge clk);
        chk_idle("mid_burst_rst");
        exp_r.delete();
        exp_w.delete();
        @(posedge clk); #1;
        rvalid = 1'b0;
        wr_valid = 1'b0;
        rst = 1'b0;
        cyc(2);

        chk("exp_ar_drained", 32'(exp_ar.size()), 32'd0);
        chk("exp_aw_drained", 32'(exp_aw.size()), 32'd0);
        chk("exp_r_drained", 32'(exp_r.size()), 32'd0);
        chk("exp_w_drained", 32'(exp_w.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
